data_mem_sized: RTL and testbench
=================================

Name: data_mem_sized

Overview:
- Parametrised data memory for the single-cycle/pipelined CPU datapath. Supersedes the plain word-only memory.
- Supports byte/half/word loads and stores with byte-lane write enables and sign/zero extension.
- Uses a valid/ready request channel, a configurable-latency response pipeline and misalignment/range error reporting.
- Runs a hardware zero-initialisation sequence after reset, so the CPU sees deterministic contents.

Parameters:
- DEPTH, 1024, memory size in 32-bit words; power of 2, minimum 4.
- ADDR_W, 32, byte-address width; must be at least log2(DEPTH)+2.
- READ_LATENCY, 1, cycles from request acceptance to response; legal range 1..4.
- INIT_ZERO, 1, 1 = clear every word after reset before accepting requests; 0 = skip clearing.

Ports:
- Clock  input  1  sole clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset; one clock, reset polarity and synchronicity fixed as stated.
- ReqValid  input  1  request present this cycle.
- Ready  output  1  block accepts a request this cycle; acceptance = ReqValid & Ready at the edge.
- WriteEnable  input  1  1 = store, 0 = load.
- Size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- Unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Address  input  ADDR_W  byte address.
- WriteData  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
- RespValid  output  1  one-cycle pulse per accepted request.
- RespData  output  32  load result, extended to 32 bits; 0 for stores and errors.
- RespError  output  1  qualifies RespValid; the request was rejected.
- InitDone  output  1  high once initialisation is complete; stays high until the next reset.

Behaviour:
- Reset (Reset_n low, any time, including mid-operation):
  - Ready=0, RespValid=0, RespData=0, RespError=0, InitDone=0.
  - All response pipeline stages flushed; in-flight requests produce no response.
  - Memory array itself is not reset.
- State machine, states INIT and RUN:
  - Reset enters INIT when INIT_ZERO=1, otherwise RUN.
  - INIT: a word counter 0..DEPTH-1 writes 0 to one word per cycle, starting the first edge after Reset_n rises. Ready=0 throughout.
  - After the counter writes word DEPTH-1, the next state is RUN and InitDone is asserted. INIT therefore lasts exactly DEPTH cycles.
  - RUN: Ready=1 continuously. One request is accepted per cycle, fully pipelined, with no backpressure.
  - With INIT_ZERO=0, InitDone and Ready go high on the first edge after Reset_n rises.
- Addressing:
  - Word index = Address[log2(DEPTH)+1:2]; lane = Address[1:0].
  - Out-of-range: any Address bit at or above log2(DEPTH)+2 is nonzero.
- Errors: Size=11, half with Address[0]=1, word with Address[1:0]≠00, or out-of-range.
  - No memory write occurs.
  - The response carries RespError=1 and RespData=0.
- Store:
  - Commits at the acceptance edge. Only the addressed lanes change: 1 byte, 2 bytes (lanes 0-1 or 2-3), or all 4.
  - A response is still returned (RespError=0, RespData=0).
- Load:
  - The array is read at the acceptance edge; the selected lane(s) are shifted down and extended per Unsigned.
  - The result travels through READ_LATENCY stages.
- Response timing: for a request accepted at edge N, RespValid/RespData/RespError are valid during the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1 they are registered at the acceptance edge. Responses return in request order.
- Read-after-write:
  - A load accepted the cycle after a store to the same word returns the updated data.
  - A load and store never coincide, since there is one request per cycle.
- Ignored inputs: WriteData and Unsigned for the unused access type; all request inputs while Ready=0.

Test Plan:
- Reset with INIT_ZERO=1, DEPTH=16: Ready=0 for exactly 16 cycles after Reset_n rises, then Ready=InitDone=1. A word load at 0x3C returns 0x00000000.
- Word store 0xDEADBEEF @0x8, then word load @0x8 on the next cycle: RespValid one cycle later, RespData=0xDEADBEEF, RespError=0.
- Byte store 0x80 @0x5 over word 0x11223344 @0x4: word reads 0x11228044. Byte load @0x5 signed gives 0xFFFFFF80; unsigned gives 0x00000080. Half load @0x6 signed gives 0x00001122.
- Error cases: half load @0x3, word store @0x2, Size=11, and an address ≥ DEPTH*4. Each gives RespValid with RespError=1 and RespData=0, and memory is unchanged (checked by word read).
- READ_LATENCY=3: four back-to-back loads @0x0,0x4,0x8,0xC. Responses appear on 4 consecutive cycles in order, the first 3 cycles after the first acceptance.
- Reset_n pulsed low mid-INIT and again with 2 loads in flight: outputs drop to 0 immediately (asynchronously), no stale RespValid afterwards, and INIT restarts from word 0 with a full DEPTH-cycle count.

Source files
------------

// File: rtl/data_mem_sized.sv
// data_mem_sized: byte/half/word data memory for the CPU datapath.
// Valid/ready request channel, byte-lane stores, sign/zero-extended loads,
// READ_LATENCY-stage response pipeline, error reporting for misaligned,
// illegal-size and out-of-range requests, and optional post-reset zero fill.
module data_mem_sized #(
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              ReqValid,
    output logic              Ready,
    input  logic              WriteEnable,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic              RespValid,
    output logic [31:0]       RespData,
    output logic              RespError,
    output logic              InitDone
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_r;
    logic [IDX_W-1:0] init_cnt_r;
    logic             ready_r;
    logic             init_done_r;
    logic [31:0]      mem_r [DEPTH];

    logic [IDX_W-1:0] idx_s;
    logic [1:0]       lane_s;
    logic             range_err_s;
    logic             err_s;
    logic             accept_s;
    logic             store_s;
    logic [3:0]       lane_mask_s;
    logic [31:0]      bit_mask_s;
    logic [31:0]      wdata_rep_s;
    logic [31:0]      rd_word_s;
    logic [31:0]      merged_s;
    logic [31:0]      shifted_s;
    logic [31:0]      load_s;
    logic [31:0]      resp_data_s;

    logic [READ_LATENCY-1:0] pv_r;
    logic [READ_LATENCY-1:0] pe_r;
    logic [31:0]             pd_r [READ_LATENCY];

    // Request decode: address split, error classification, lane masks, load extraction.
    always_comb begin
        idx_s       = Address[IDX_W+1:2];
        lane_s      = Address[1:0];
        // Any address bit above the array span makes the request out of range.
        range_err_s = ((Address >> (IDX_W + 2)) != {ADDR_W{1'b0}});
        accept_s    = ReqValid & ready_r;
        rd_word_s   = mem_r[idx_s];
        shifted_s   = rd_word_s >> {lane_s, 3'b000};
        err_s       = range_err_s;
        lane_mask_s = 4'b0000;
        wdata_rep_s = 32'h0000_0000;
        load_s      = 32'h0000_0000;
        case (Size)
            2'b00: begin
                lane_mask_s = 4'b0001 << lane_s;
                wdata_rep_s = {4{WriteData[7:0]}};
                if (Unsigned) begin
                    load_s = {24'h00_0000, shifted_s[7:0]};
                end else begin
                    load_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            2'b01: begin
                err_s       = range_err_s | Address[0];
                lane_mask_s = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_rep_s = {2{WriteData[15:0]}};
                if (Unsigned) begin
                    load_s = {16'h0000, shifted_s[15:0]};
                end else begin
                    load_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            2'b10: begin
                err_s       = range_err_s | (lane_s != 2'b00);
                lane_mask_s = 4'b1111;
                wdata_rep_s = WriteData;
                load_s      = rd_word_s;
            end
            default: begin
                err_s = 1'b1;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            bit_mask_s[8*i +: 8] = {8{lane_mask_s[i]}};
        end
        merged_s    = (rd_word_s & ~bit_mask_s) | (wdata_rep_s & bit_mask_s);
        store_s     = accept_s & WriteEnable & ~err_s;
        resp_data_s = (WriteEnable | err_s) ? 32'h0000_0000 : load_s;
    end

    // INIT/RUN sequencing: zero-fill counter, Ready and InitDone generation.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            init_cnt_r  <= {IDX_W{1'b0}};
            ready_r     <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + 1'b1;
                    if (init_cnt_r == IDX_W'(DEPTH - 1)) begin
                        state_r     <= ST_RUN;
                        ready_r     <= 1'b1;
                        init_done_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_r     <= 1'b1;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= {IDX_W{1'b0}};
                    ready_r    <= 1'b0;
                end
            endcase
        end
    end

    // Array write port: zero fill during INIT, lane-merged store in RUN (array is not reset).
    always_ff @(posedge Clock) begin
        if (state_r == ST_INIT) begin
            mem_r[init_cnt_r] <= 32'h0000_0000;
        end else if (store_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    // Response pipeline: stage 0 captures the result at acceptance, later stages delay it.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pv_r <= {READ_LATENCY{1'b0}};
            pe_r <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                pd_r[i] <= 32'h0000_0000;
            end
        end else begin
            pv_r[0] <= accept_s;
            pe_r[0] <= accept_s & err_s;
            pd_r[0] <= accept_s ? resp_data_s : 32'h0000_0000;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_r[i] <= pv_r[i-1];
                pe_r[i] <= pe_r[i-1];
                pd_r[i] <= pd_r[i-1];
            end
        end
    end

    assign Ready     = ready_r;
    assign InitDone  = init_done_r;
    assign RespValid = pv_r[READ_LATENCY-1];
    assign RespError = pe_r[READ_LATENCY-1];
    assign RespData  = pd_r[READ_LATENCY-1];

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized: two DEPTH=16 instances (latency 1 and 3)
// share stimulus; each has its own expected-response queue checked on RespValid.
module tb_data_mem_sized;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ReqValid = 1'b0;
    logic        WriteEnable = 1'b0;
    logic [1:0]  Size = 2'b10;
    logic        Unsigned = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;

    logic        ready_a, resp_valid_a, resp_error_a, init_done_a;
    logic [31:0] resp_data_a;
    logic        ready_b, resp_valid_b, resp_error_b, init_done_b;
    logic [31:0] resp_data_b;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t qa[$];
    exp_t qb[$];

    data_mem_sized #(.DEPTH(16), .ADDR_W(32), .READ_LATENCY(1), .INIT_ZERO(1)) dut_a (
        .Clock(Clock), .Reset_n(Reset_n), .ReqValid(ReqValid), .Ready(ready_a),
        .WriteEnable(WriteEnable), .Size(Size), .Unsigned(Unsigned), .Address(Address),
        .WriteData(WriteData), .RespValid(resp_valid_a), .RespData(resp_data_a),
        .RespError(resp_error_a), .InitDone(init_done_a)
    );

    data_mem_sized #(.DEPTH(16), .ADDR_W(32), .READ_LATENCY(3), .INIT_ZERO(1)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n), .ReqValid(ReqValid), .Ready(ready_b),
        .WriteEnable(WriteEnable), .Size(Size), .Unsigned(Unsigned), .Address(Address),
        .WriteData(WriteData), .RespValid(resp_valid_b), .RespData(resp_data_b),
        .RespError(resp_error_b), .InitDone(init_done_b)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the latency-1 instance.
    always @(negedge Clock) begin
        exp_t e;
        if (resp_valid_a === 1'b1) begin
            check("a_resp_expected", 32'(qa.size() > 0), 32'd1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a_resp_data", resp_data_a, e.data);
                check("a_resp_error", 32'(resp_error_a), 32'(e.err));
                check("a_resp_latency", cyc - e.cyc, 32'd1);
            end
        end
    end

    // Scoreboard for the latency-3 instance.
    always @(negedge Clock) begin
        exp_t e;
        if (resp_valid_b === 1'b1) begin
            check("b_resp_expected", 32'(qb.size() > 0), 32'd1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b_resp_data", resp_data_b, e.data);
                check("b_resp_error", 32'(resp_error_b), 32'(e.err));
                check("b_resp_latency", cyc - e.cyc, 32'd3);
            end
        end
    end

    task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        @(negedge Clock);
        ReqValid    = 1'b1;
        WriteEnable = we;
        Size        = sz;
        Unsigned    = uns;
        Address     = addr;
        WriteData   = wd;
        e.data = exp_data;
        e.err  = exp_err;
        e.cyc  = cyc;
        qa.push_back(e);
        qb.push_back(e);
    endtask

    task automatic idle();
        @(negedge Clock);
        ReqValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("queues_drained", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 32'({ready_a, ready_b}), 32'd0);
        check({tag, "_initdone"}, 32'({init_done_a, init_done_b}), 32'd0);
        check({tag, "_respvalid"}, 32'({resp_valid_a, resp_valid_b}), 32'd0);
        check({tag, "_resperror"}, 32'({resp_error_a, resp_error_b}), 32'd0);
        check({tag, "_respdata_a"}, resp_data_a, 32'h0);
        check({tag, "_respdata_b"}, resp_data_b, 32'h0);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (ready_a !== 1'b1 && n < 100) begin
            @(posedge Clock);
            #1;
            n++;
        end
        check({tag, "_init_cycles"}, n, 32'd16);
        check({tag, "_ready_b"}, 32'(ready_b), 32'd1);
        check({tag, "_initdone"}, 32'({init_done_a, init_done_b}), 32'd3);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset state.
        Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        check_outputs_zero("reset");
        Reset_n = 1'b1;
        wait_init("init1");

        // Cleared memory, word store then load on the next cycle.
        req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0);
        req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0);
        req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte merge and extension cases.
        req(1'b1, 2'b10, 1'b0, 32'h04, 32'h1122_3344, 32'h0, 1'b0);
        req(1'b1, 2'b00, 1'b1, 32'h05, 32'hAAAA_AA80, 32'h0, 1'b0);
        req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h1122_8044, 1'b0);
        req(1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 32'hFFFF_FF80, 1'b0);
        req(1'b0, 2'b00, 1'b1, 32'h05, 32'h0, 32'h0000_0080, 1'b0);
        req(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 32'h0000_1122, 1'b0);
        req(1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 32'hFFFF_8044, 1'b0);
        req(1'b0, 2'b01, 1'b1, 32'h04, 32'h0, 32'h0000_8044, 1'b0);

        // Error cases, then confirm memory untouched.
        req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1);
        req(1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFF_FFFF, 32'h0, 1'b1);
        req(1'b1, 2'b11, 1'b0, 32'h08, 32'h0, 32'h0, 1'b1);
        req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b1);
        req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h0000_0000, 1'b0);
        req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Upper-half store with junk in the unused bits.
        req(1'b1, 2'b01, 1'b0, 32'h02, 32'h5555_BEEF, 32'h0, 1'b0);

        // Four back-to-back loads.
        req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hBEEF_0000, 1'b0);
        req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h1122_8044, 1'b0);
        req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0);
        req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h0000_0000, 1'b0);
        idle();
        drain();

        // Reset pulsed mid-INIT.
        @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        check_outputs_zero("rst_a");
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (5) @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid_init");
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        wait_init("init2");

        // Two loads in flight when reset hits.
        req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);
        req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
        @(posedge Clock);
        #2;
        check("inflight_respvalid_a", 32'(resp_valid_a), 32'd1);
        Reset_n  = 1'b0;
        ReqValid = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check_outputs_zero("rst_inflight");

        // A store presented while Ready is low must be ignored.
        repeat (2) @(negedge Clock);
        ReqValid    = 1'b1;
        WriteEnable = 1'b1;
        Size        = 2'b10;
        Address     = 32'h08;
        WriteData   = 32'h1234_5678;
        Reset_n     = 1'b1;
        wait_init("init3");
        ReqValid = 1'b0;

        // INIT cleared the array again.
        req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h0000_0000, 1'b0);
        req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h0000_0000, 1'b0);
        idle();
        drain();
        repeat (4) @(negedge Clock);
        check("final_queue_a", 32'(qa.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
